// File: rtl/btn_pkg.sv
// Constants shared between the button front end and the LED display logic.
package btn_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_INCR = 2'b01;
  localparam logic [1:0] CMD_DECR = 2'b10;

  localparam logic MODE_SINE   = 1'b0;
  localparam logic MODE_UPDOWN = 1'b1;

endpackage

// File: rtl/button_debouncer.sv
// One push-button: metastability synchronizer, counter debouncer and rising-edge detect.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_db,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   db_q;
  logic                   db_dly_q;
  logic [CNT_W-1:0]       cnt_q;

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q   <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], i_btn};
      db_dly_q <= db_q;
      // Counter only runs while the sample disagrees, and clears on acceptance.
      if (sample == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        db_q  <= sample;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_db   = db_q;
  assign o_rise = db_q & ~db_dly_q;

endmodule

// File: rtl/button_input_conditioner.sv
// Turns the raw up/down/mode buttons into registered mode and increment/decrement commands.
module button_input_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_mode,
  output logic       o_mode,
  output logic [1:0] o_incr_decr,
  output logic [1:0] o_incr_decr_pulse,
  output logic       o_mode_pulse
);

  logic up_db, up_rise;
  logic down_db, down_rise;
  logic mode_db_unused, mode_rise;
  logic [1:0] cmd_level;
  logic [1:0] cmd_pulse;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_up (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_up),
    .o_db  (up_db),
    .o_rise(up_rise)
  );

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_down (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_down),
    .o_db  (down_db),
    .o_rise(down_rise)
  );

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_mode (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_btn (i_btn_mode),
    .o_db  (mode_db_unused),
    .o_rise(mode_rise)
  );

  // Conflicting buttons cancel; a rise only strobes if the other button is released.
  always_comb begin
    cmd_level = CMD_NONE;
    cmd_pulse = CMD_NONE;
    if (up_db && !down_db) begin
      cmd_level = CMD_INCR;
    end else if (down_db && !up_db) begin
      cmd_level = CMD_DECR;
    end
    if (up_rise && !down_db) begin
      cmd_pulse = CMD_INCR;
    end else if (down_rise && !up_db) begin
      cmd_pulse = CMD_DECR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mode            <= MODE_SINE;
      o_mode_pulse      <= 1'b0;
      o_incr_decr       <= CMD_NONE;
      o_incr_decr_pulse <= CMD_NONE;
    end else begin
      o_mode_pulse      <= mode_rise;
      o_incr_decr       <= cmd_level;
      o_incr_decr_pulse <= cmd_pulse;
      if (mode_rise) begin
        o_mode <= ~o_mode;
      end
    end
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner with a short debounce window.
module tb_button_input_conditioner;

  logic       clk;
  logic       rst;
  logic       btn_up, btn_down, btn_mode;
  logic       o_mode;
  logic [1:0] o_incr_decr;
  logic [1:0] o_incr_decr_pulse;
  logic       o_mode_pulse;

  int checks = 0;
  int passed = 0;

  button_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_btn_up         (btn_up),
    .i_btn_down       (btn_down),
    .i_btn_mode       (btn_mode),
    .o_mode           (o_mode),
    .o_incr_decr      (o_incr_decr),
    .o_incr_decr_pulse(o_incr_decr_pulse),
    .o_mode_pulse     (o_mode_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       up;
    logic       down;
    logic       mode;
    logic [1:0] lvl;
    logic [1:0] pls;
    logic       m;
    logic       mp;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic u, input logic d, input logic m);
    rst      = r;
    btn_up   = u;
    btn_down = d;
    btn_mode = m;
  endtask

  task automatic chk(input string name, input logic [1:0] lvl, input logic [1:0] pls,
                     input logic m, input logic mp);
    checks++;
    if ({o_incr_decr, o_incr_decr_pulse, o_mode, o_mode_pulse} !== {lvl, pls, m, mp}) begin
      $display("FAIL %s @%0t: got lvl=%b pls=%b mode=%b mpls=%b, want lvl=%b pls=%b mode=%b mpls=%b",
               name, $time, o_incr_decr, o_incr_decr_pulse, o_mode, o_mode_pulse,
               lvl, pls, m, mp);
    end else begin
      passed++;
    end
  endtask

  // Advance n edges, checking the same expected outputs after each one.
  task automatic hold(input int n, input string name, input logic [1:0] lvl,
                      input logic [1:0] pls, input logic m, input logic mp);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(name, lvl, pls, m, mp);
    end
  endtask

  initial begin
    // Reset with every button held, then release reset and let presses be accepted.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
    for (int i = 11; i < 17; i++) begin
      vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    end

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].rst, vecs[i].up, vecs[i].down, vecs[i].mode);
      tick();
      chk($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pls, vecs[i].m, vecs[i].mp);
    end
    hold(4, "settle", 2'b00, 2'b00, 1'b1, 1'b0);

    // Steady up press for 20 cycles, then release.
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    hold(6, "up_wait", 2'b00, 2'b00, 1'b1, 1'b0);
    hold(1, "up_accept", 2'b01, 2'b01, 1'b1, 1'b0);
    hold(13, "up_held", 2'b01, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(6, "up_rel_wait", 2'b01, 2'b00, 1'b1, 1'b0);
    hold(4, "up_released", 2'b00, 2'b00, 1'b1, 1'b0);

    // Down glitches of 3 cycles are rejected.
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    hold(3, "glitch_a", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(1, "glitch_gap", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    hold(3, "glitch_b", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(10, "glitch_after", 2'b00, 2'b00, 1'b1, 1'b0);

    // Steady down press of 10 cycles.
    set_in(1'b0, 1'b0, 1'b1, 1'b0);
    hold(6, "down_wait", 2'b00, 2'b00, 1'b1, 1'b0);
    hold(1, "down_accept", 2'b10, 2'b10, 1'b1, 1'b0);
    hold(3, "down_held", 2'b10, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(6, "down_rel_wait", 2'b10, 2'b00, 1'b1, 1'b0);
    hold(4, "down_released", 2'b00, 2'b00, 1'b1, 1'b0);

    // Exactly DEBOUNCE_CYCLES raw cycles of up is the shortest accepted press.
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    hold(4, "min_press", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(2, "min_wait", 2'b00, 2'b00, 1'b1, 1'b0);
    hold(1, "min_accept", 2'b01, 2'b01, 1'b1, 1'b0);
    hold(3, "min_level", 2'b01, 2'b00, 1'b1, 1'b0);
    hold(5, "min_release", 2'b00, 2'b00, 1'b1, 1'b0);

    // Up and down together cancel; dropping down leaves a pulseless increment level.
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    hold(12, "both", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    hold(6, "drop_down_wait", 2'b00, 2'b00, 1'b1, 1'b0);
    hold(4, "drop_down", 2'b01, 2'b00, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(6, "both_rel_wait", 2'b01, 2'b00, 1'b1, 1'b0);
    hold(4, "both_released", 2'b00, 2'b00, 1'b1, 1'b0);

    // Reset while up is mid-debounce; the held press is re-accepted afterwards.
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    hold(4, "mid_deb", 2'b00, 2'b00, 1'b1, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    hold(1, "mid_rst", 2'b00, 2'b00, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    hold(6, "post_rst_wait", 2'b00, 2'b00, 1'b0, 1'b0);
    hold(1, "post_rst_accept", 2'b01, 2'b01, 1'b0, 1'b0);
    hold(2, "post_rst_held", 2'b01, 2'b00, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    hold(6, "post_rst_rel_wait", 2'b01, 2'b00, 1'b0, 1'b0);
    hold(4, "post_rst_released", 2'b00, 2'b00, 1'b0, 1'b0);

    // Three mode presses toggle 0->1->0->1 with one strobe each.
    for (int p = 0; p < 3; p++) begin
      logic cur;
      cur = (p == 1) ? 1'b1 : 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      hold(6, $sformatf("mode%0d_wait", p), 2'b00, 2'b00, cur, 1'b0);
      hold(1, $sformatf("mode%0d_toggle", p), 2'b00, 2'b00, ~cur, 1'b1);
      hold(3, $sformatf("mode%0d_held", p), 2'b00, 2'b00, ~cur, 1'b0);
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      hold(10, $sformatf("mode%0d_gap", p), 2'b00, 2'b00, ~cur, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
